// File: rtl/mac_pkg.sv
// Shared RMII MAC definitions: line symbols, CRC-32 constants, FSM states, and the dibit helpers
// used by both the receive and transmit paths.
package mac_pkg;
  localparam logic [1:0]  PRE_DIBIT      = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam int          MIN_DATA_BYTES = 46;
  localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_PRE, ST_DST, ST_SRC, ST_TYPE, ST_DATA, ST_FCS, ST_CHECK, ST_DROP, ST_WAIT
  } mac_state_e;

  // Reflected CRC-32 advanced by one dibit, din[0] being the earlier bit on the wire.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] din);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) r = (r >> 1) ^ ((r[0] ^ din[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  // Dibit k of a big-endian field of nbytes bytes, each byte sent LSB dibit first.
  function automatic logic [1:0] field_dibit(input logic [47:0] f, input int nbytes, input int k);
    logic [47:0] t;
    t = f >> (8 * (nbytes - 1 - k / 4) + 2 * (k % 4));
    return t[1:0];
  endfunction
endpackage

// File: rtl/crc32_dibit.sv
// Two-bit-per-cycle reflected CRC-32 register; clear has priority over enable.
module crc32_dibit
  import mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [1:0]  din,
  output logic [31:0] crc
);
  logic [31:0] crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_q <= CRC_INIT;
    else if (clear)  crc_q <= CRC_INIT;
    else if (enable) crc_q <= crc_step(crc_q, din);
  end

  assign crc = crc_q;
endmodule

// File: rtl/mac_rx.sv
// RMII receive MAC: preamble/SFD detection, destination and ethertype filtering, FCS check,
// and a fixed-length payload presented with a one-cycle valid strobe.
module mac_rx
  import mac_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC             = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE            = 16'h88_B5,
  parameter int          PAYLOAD_LENGTH_BYTES = 5,
  parameter int          PREAMBLE_MIN_DIBITS  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              crsdv,
  input  logic [1:0]                        rxd,
  output logic [8*PAYLOAD_LENGTH_BYTES-1:0] payload_o,
  output logic [47:0]                       src_mac_o,
  output logic                              valid_o,
  output logic                              drop_o
);
  localparam int P          = PAYLOAD_LENGTH_BYTES;
  localparam int PW         = 8 * P;
  localparam int DATA_BYTES = (P > MIN_DATA_BYTES) ? P : MIN_DATA_BYTES;
  localparam int CW         = $clog2(4 * DATA_BYTES);

  localparam logic [CW-1:0] LAST_MAC   = CW'(23);
  localparam logic [CW-1:0] LAST_TYPE  = CW'(7);
  localparam logic [CW-1:0] LAST_FCS   = CW'(15);
  localparam logic [CW-1:0] LAST_DATA  = CW'(4 * DATA_BYTES - 1);
  localparam logic [CW-1:0] PAY_DIBITS = CW'(4 * P);
  localparam logic [4:0]    PRE_MIN    = 5'(PREAMBLE_MIN_DIBITS);

  mac_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    pre_q, pre_d;
  logic          type_err_q, type_err_d;
  logic [47:0]   src_stg_q, src_stg_d, src_q, src_d;
  logic [PW-1:0] pay_stg_q, pay_stg_d, payload_q, payload_d;
  logic          valid_q, valid_d, drop_q, drop_d;
  logic          crc_clear, crc_en;
  logic [31:0]   crc, crc_nxt;
  logic [1:0]    dst_exp, type_exp;
  logic [CW-3:0] byte_idx;
  logic [1:0]    dib_idx;

  crc32_dibit u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (crc_clear),
    .enable (crc_en),
    .din    (rxd),
    .crc    (crc)
  );

  assign crc_nxt  = crc_step(crc, rxd);
  assign dst_exp  = field_dibit(FPGA_MAC, 6, int'(cnt_q));
  assign type_exp = field_dibit({32'h0, ETHERTYPE}, 2, int'(cnt_q));
  assign byte_idx = cnt_q[CW-1:2];
  assign dib_idx  = cnt_q[1:0];

  // The good/bad verdict is taken on the last FCS dibit so the strobe and the new outputs
  // appear together during the CHECK cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    type_err_d = type_err_q;
    src_stg_d  = src_stg_q;
    pay_stg_d  = pay_stg_q;
    payload_d  = payload_q;
    src_d      = src_q;
    valid_d    = 1'b0;
    drop_d     = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    case (state_q)
      ST_IDLE: if (crsdv && rxd == PRE_DIBIT) begin
        state_d = ST_PRE;
        pre_d   = 5'd1;
      end
      ST_PRE: begin
        if (!crsdv) state_d = ST_IDLE;
        else if (rxd == PRE_DIBIT) begin
          if (pre_q != 5'h1F) pre_d = pre_q + 5'd1;
        end else if (rxd == SFD_DIBIT && pre_q >= PRE_MIN) begin
          state_d   = ST_DST;
          cnt_d     = '0;
          crc_clear = 1'b1;
        end else begin
          state_d = ST_DROP;
          drop_d  = 1'b1;
        end
      end
      ST_DST, ST_SRC, ST_TYPE, ST_DATA, ST_FCS: begin
        if (!crsdv) begin
          state_d = ST_IDLE;
          drop_d  = 1'b1;
        end else begin
          crc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          case (state_q)
            ST_DST: begin
              if (rxd != dst_exp) begin
                state_d = ST_DROP;
                drop_d  = 1'b1;
              end else if (cnt_q == LAST_MAC) begin
                state_d = ST_SRC;
                cnt_d   = '0;
              end
            end
            ST_SRC: begin
              src_stg_d[8 * (5 - int'(byte_idx)) + 2 * int'(dib_idx) +: 2] = rxd;
              if (cnt_q == LAST_MAC) begin
                state_d    = ST_TYPE;
                cnt_d      = '0;
                type_err_d = 1'b0;
              end
            end
            ST_TYPE: begin
              if (cnt_q == LAST_TYPE) begin
                cnt_d = '0;
                if (type_err_q || rxd != type_exp) begin
                  state_d = ST_DROP;
                  drop_d  = 1'b1;
                end else state_d = ST_DATA;
              end else if (rxd != type_exp) type_err_d = 1'b1;
            end
            ST_DATA: begin
              // Pad bytes beyond the payload only feed the CRC.
              if (cnt_q < PAY_DIBITS)
                pay_stg_d[8 * (P - 1 - int'(byte_idx)) + 2 * int'(dib_idx) +: 2] = rxd;
              if (cnt_q == LAST_DATA) begin
                state_d = ST_FCS;
                cnt_d   = '0;
              end
            end
            ST_FCS: begin
              if (cnt_q == LAST_FCS) begin
                state_d = ST_CHECK;
                cnt_d   = '0;
                if (crc_nxt == CRC_RESIDUE) begin
                  valid_d   = 1'b1;
                  payload_d = pay_stg_q;
                  src_d     = src_stg_q;
                end else drop_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      // Going straight to IDLE on a low crsdv lets a one-cycle inter-frame gap work.
      ST_CHECK, ST_DROP: state_d = crsdv ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (!crsdv) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pre_q      <= '0;
      type_err_q <= 1'b0;
      src_stg_q  <= '0;
      pay_stg_q  <= '0;
      src_q      <= '0;
      payload_q  <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pre_q      <= pre_d;
      type_err_q <= type_err_d;
      src_stg_q  <= src_stg_d;
      pay_stg_q  <= pay_stg_d;
      src_q      <= src_d;
      payload_q  <= payload_d;
      valid_q    <= valid_d;
      drop_q     <= drop_d;
    end
  end

  assign payload_o = payload_q;
  assign src_mac_o = src_q;
  assign valid_o   = valid_q;
  assign drop_o    = drop_q;
endmodule

// File: tb/tb_mac_rx.sv
// Directed bench for mac_rx: builds complete RMII frames (preamble, headers, padded data, FCS)
// and checks strobe counts, strobe positions and held outputs.
module tb_mac_rx;
  localparam logic [47:0] FPGA_MAC = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] HOST_MAC = 48'h00_E0_4C_68_1E_0C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        crsdv = 1'b0;
  logic [1:0]  rxd = 2'b00;
  logic [39:0] payload_o;
  logic [47:0] src_mac_o;
  logic        valid_o, drop_o;

  mac_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .crsdv     (crsdv),
    .rxd       (rxd),
    .payload_o (payload_o),
    .src_mac_o (src_mac_o),
    .valid_o   (valid_o),
    .drop_o    (drop_o)
  );

  always #10 clk = ~clk;

  int total = 0, bad = 0;
  logic [1:0] dib[0:511];
  int ndib = 0;
  int n_valid, n_drop, valid_tag, drop_tag, last_tag = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) begin
      dib[ndib] = b[2*k +: 2];
      ndib++;
    end
  endfunction

  function automatic void build(input logic [47:0] dst, input logic [47:0] src,
                                input logic [15:0] et, input logic [39:0] pay, input bit flip);
    logic [7:0]  fr[0:63];
    logic [31:0] c;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = dst[47 - 8*i -: 8];
      fr[6 + i] = src[47 - 8*i -: 8];
    end
    fr[12] = et[15:8];
    fr[13] = et[7:0];
    for (int i = 0; i < 46; i++) fr[14 + i] = (i < 5) ? pay[39 - 8*i -: 8] : 8'h00;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      c = c ^ {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr[60 + i] = c[8*i +: 8];
    if (flip) fr[16][3] = ~fr[16][3];
    ndib = 0;
    for (int i = 0; i < 7; i++) push_byte(8'h55);
    push_byte(8'hD5);
    for (int i = 0; i < 64; i++) push_byte(fr[i]);
  endfunction

  // Called on a falling edge; last_tag is the index of the dibit driven one cycle earlier.
  task automatic sample();
    if (valid_o || drop_o) begin
      total++;
      if (valid_o && drop_o) begin
        bad++;
        $display("FAIL overlap: valid=%0b drop=%0b want not both", valid_o, drop_o);
      end
    end
    if (valid_o) begin
      n_valid++;
      valid_tag = last_tag;
    end
    if (drop_o) begin
      n_drop++;
      if (drop_tag < 0) drop_tag = last_tag;
    end
  endtask

  task automatic clear_ev();
    n_valid = 0; n_drop = 0; valid_tag = -1; drop_tag = -1;
  endtask

  task automatic send(input int abort_at, input int gap);
    int n_eff;
    n_eff = (abort_at >= 0) ? abort_at : ndib;
    for (int i = 0; i < n_eff; i++) begin
      @(negedge clk);
      sample();
      crsdv = 1'b1;
      rxd = dib[i];
      last_tag = i;
    end
    @(negedge clk);
    sample();
    crsdv = 1'b0;
    rxd = 2'b00;
    last_tag = n_eff;
    for (int g = 1; g < gap; g++) begin
      @(negedge clk);
      sample();
      last_tag++;
    end
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    logic [39:0] pay;
    bit          flip;
    int          abort_at;
    int          exp_valid;
    int          exp_drop;
    int          exp_tag;
    logic [39:0] exp_pay;
    logic [47:0] exp_src;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{FPGA_MAC, HOST_MAC, 16'h88B5, 40'h01_0002_0001, 1'b0, -1, 1, 0, 287,
               40'h01_0002_0001, HOST_MAC};
    tbl[1] = '{48'h69_69_5A_06_54_92, HOST_MAC, 16'h88B5, 40'h01_0002_0001, 1'b0, -1, 0, 1, 52,
               40'h01_0002_0001, HOST_MAC};
    tbl[2] = '{FPGA_MAC, HOST_MAC, 16'h0800, 40'h01_0002_0001, 1'b0, -1, 0, 1, 87,
               40'h01_0002_0001, HOST_MAC};
    tbl[3] = '{FPGA_MAC, HOST_MAC, 16'h88B5, 40'h01_0002_0001, 1'b1, -1, 0, 1, 287,
               40'h01_0002_0001, HOST_MAC};
    tbl[4] = '{FPGA_MAC, 48'h02_11_22_33_44_55, 16'h88B5, 40'h11_2233_4455, 1'b0, -1, 1, 0, 287,
               40'h11_2233_4455, 48'h02_11_22_33_44_55};
    tbl[5] = '{FPGA_MAC, HOST_MAC, 16'h88B5, 40'h99_8877_6655, 1'b0, 150, 0, 1, 150,
               40'h11_2233_4455, 48'h02_11_22_33_44_55};

    repeat (2) @(negedge clk);
    chk("rst_payload", 64'(payload_o), 64'h0);
    chk("rst_src", 64'(src_mac_o), 64'h0);
    chk("rst_valid", 64'(valid_o), 64'h0);
    chk("rst_drop", 64'(drop_o), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      clear_ev();
      build(tbl[v].dst, tbl[v].src, tbl[v].et, tbl[v].pay, tbl[v].flip);
      send(tbl[v].abort_at, 4);
      chk($sformatf("v%0d_nvalid", v), 64'(n_valid), 64'(tbl[v].exp_valid));
      chk($sformatf("v%0d_ndrop", v), 64'(n_drop), 64'(tbl[v].exp_drop));
      chk($sformatf("v%0d_tag", v), 64'(tbl[v].exp_valid != 0 ? valid_tag : drop_tag),
          64'(tbl[v].exp_tag));
      chk($sformatf("v%0d_payload", v), 64'(payload_o), 64'(tbl[v].exp_pay));
      chk($sformatf("v%0d_src", v), 64'(src_mac_o), 64'(tbl[v].exp_src));
    end

    // Aborted frame followed by a clean one after a single low cycle of crsdv.
    clear_ev();
    build(FPGA_MAC, HOST_MAC, 16'h88B5, 40'h55_5555_5555, 1'b0);
    send(150, 1);
    build(FPGA_MAC, HOST_MAC, 16'h88B5, 40'hAA_BBCC_DDEE, 1'b0);
    send(-1, 4);
    chk("b2b_ndrop", 64'(n_drop), 64'd1);
    chk("b2b_drop_tag", 64'(drop_tag), 64'd150);
    chk("b2b_nvalid", 64'(n_valid), 64'd1);
    chk("b2b_valid_tag", 64'(valid_tag), 64'd287);
    chk("b2b_payload", 64'(payload_o), 64'hAA_BBCC_DDEE);

    // Reset asserted in the middle of the source MAC field.
    clear_ev();
    build(FPGA_MAC, HOST_MAC, 16'h88B5, 40'h77_6655_4433, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      sample();
      crsdv = 1'b1;
      rxd = dib[i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    rxd = dib[64];
    #1;
    chk("mid_rst_payload", 64'(payload_o), 64'h0);
    chk("mid_rst_src", 64'(src_mac_o), 64'h0);
    chk("mid_rst_valid", 64'(valid_o), 64'h0);
    chk("mid_rst_drop", 64'(drop_o), 64'h0);
    for (int i = 65; i < 80; i++) begin
      @(negedge clk);
      sample();
      rxd = dib[i];
    end
    @(negedge clk);
    crsdv = 1'b0;
    rxd = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      sample();
    end
    chk("rst_abort_nvalid", 64'(n_valid), 64'd0);
    chk("rst_abort_ndrop", 64'(n_drop), 64'd0);

    clear_ev();
    build(FPGA_MAC, HOST_MAC, 16'h88B5, 40'h12_3456_789A, 1'b0);
    send(-1, 4);
    chk("post_rst_nvalid", 64'(n_valid), 64'd1);
    chk("post_rst_ndrop", 64'(n_drop), 64'd0);
    chk("post_rst_payload", 64'(payload_o), 64'h12_3456_789A);
    chk("post_rst_src", 64'(src_mac_o), 64'(HOST_MAC));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_rx.md
Name: mac_rx

Overview:
- RMII receive MAC that turns raw PHY dibits (crsdv/rxd) into verified frame payloads.
- Detects preamble/SFD, filters on destination MAC and ethertype, checks FCS, and presents a fixed-length payload with a one-cycle valid strobe.
- Sits directly upstream of the Ethernet bus-decoding stage.
- Mirror image of mac_tx: a frame produced by mac_tx with matching parameters must be accepted bit-exactly.

Parameters:
- FPGA_MAC, 48'h69_69_5A_06_54_91, destination MAC accepted; all other destinations are dropped.
- ETHERTYPE, 16'h88_B5, ethertype accepted.
- PAYLOAD_LENGTH_BYTES, 5, payload bytes delivered on payload_o.
- PREAMBLE_MIN_DIBITS, 4, minimum count of 2'b01 dibits required before the SFD dibit.

Ports:
- clk  in  1  50 MHz RMII reference clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- crsdv  in  1  RMII carrier-sense/data-valid, already synchronous to clk.
- rxd  in  2  RMII receive dibit.
- payload_o  out  8*PAYLOAD_LENGTH_BYTES  payload; first received byte in the MSBs.
- src_mac_o  out  48  source MAC of the last accepted frame.
- valid_o  out  1  one-cycle strobe for an accepted frame.
- drop_o  out  1  one-cycle strobe when a started frame is discarded.

Behaviour:
- Reset: payload_o=0, src_mac_o=0, valid_o=0, drop_o=0, state=IDLE, counters=0, CRC=32'hFFFF_FFFF.
- Wire order: bytes MSB-byte-first for MAC, ethertype and payload fields; each byte arrives LSB dibit first (bits[1:0] first).
- Data field length D = max(PAYLOAD_LENGTH_BYTES, 46). Pad bytes beyond PAYLOAD_LENGTH_BYTES enter the CRC but are not stored.

States:
- IDLE:
  - crsdv=1 and rxd=01 -> PREAMBLE, preamble count=1.
  - Anything else stays in IDLE.
- PREAMBLE:
  - rxd=01: increment count (saturating).
  - rxd=11 with count>=PREAMBLE_MIN_DIBITS -> DST; clear CRC and byte/dibit counters.
  - rxd=11 with count too low, or rxd=00/10 -> DROP.
- DST: 24 dibits.
  - Compare on the fly; first mismatch -> DROP (no need to wait for end of field).
- SRC: 24 dibits, shifted into a staging register.
- TYPE: 8 dibits.
  - Mismatch against ETHERTYPE -> DROP, checked at the last dibit.
- DATA: 4*D dibits.
  - Only the first 4*PAYLOAD_LENGTH_BYTES dibits go into the staging payload register.
- FCS: 16 dibits.
  - After the last dibit, a CRC register equal to 32'hDEBB_20E3 means good; otherwise bad.
- CHECK (one cycle):
  - Good: copy staging registers to payload_o/src_mac_o and pulse valid_o.
  - Bad: pulse drop_o.
  - Then -> WAIT_IDLE.
- DROP: pulse drop_o once on entry, then -> WAIT_IDLE.
- WAIT_IDLE: stay until crsdv=0, then -> IDLE. Trailing bytes and extra data are ignored.

CRC:
- Reflected CRC-32, polynomial 32'hEDB8_8320, init all-ones, 2 bits per cycle.
- Covers DST through FCS inclusive.

Timing and boundary cases:
- Latency: valid_o is high exactly one cycle, in the cycle after the cycle in which the last FCS dibit is sampled.
- crsdv=0 in any state from PREAMBLE through FCS aborts the frame: drop_o pulses, -> IDLE.
  - Exception: in PREAMBLE, crsdv=0 returns to IDLE silently, with no drop_o.
- payload_o/src_mac_o change only on valid_o and hold otherwise. Staging registers are separate so a dropped frame never corrupts the outputs.
- valid_o and drop_o are never high together.
- Reset mid-frame: immediate return to reset values. The remainder of that frame is not accepted, because IDLE requires a fresh 01 preamble start.
- Back-to-back frames: the minimum 1-cycle crsdv low gap must be accepted.

Decomposition:
- Package mac_pkg:
  - Constants: SFD dibit 2'b11, preamble dibit 2'b01, MIN_DATA_BYTES=46, CRC_POLY, CRC_INIT, CRC_RESIDUE.
  - State enum type.
  - Shared with mac_tx.
- Sub-module crc32_dibit:
  - Ports: clk, rst_n, clear, enable, din[1:0], crc[31:0].
  - One-cycle register update; reusable by mac_tx.
- mac_rx holds the FSM, counters and staging registers.

Test Plan:
- mac_tx (HOST_MAC src, FPGA_MAC dst, 88B5) sends payload 40'h01_0002_0001 -> exactly one valid_o pulse; payload_o=40'h01_0002_0001; src_mac_o=48'h00_E0_4C_68_1E_0C; drop_o never high.
- Same frame with dst 48'h69_69_5A_06_54_92 -> drop_o pulse during DST; no valid_o; payload_o unchanged.
- Ethertype 16'h0800 -> drop_o pulse at end of TYPE; no valid_o.
- One payload bit flipped in flight -> drop_o pulse in CHECK; outputs still hold the previous good frame.
- crsdv forced low mid-DATA, then a clean frame with payload 40'hAA_BBCC_DDEE after a 1-cycle gap -> first frame gives drop_o; second gives valid_o with 40'hAA_BBCC_DDEE.
- rst_n asserted mid-SRC, released, then a clean frame sent -> no pulse for the aborted frame; clean frame gives valid_o; all outputs are zero during reset.
